// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data memory with wait-state latency.
// Performs lw/lb/lbu/sw/sb, stalls upstream while an access is in flight and
// sends a bubble to MEM/WB during the stall.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   MEM_* inputs           - EX/MEM payload (controls, address, store data, dest reg)
//   MEM_Stall              - freeze PC, IF/ID, ID/EX, EX/MEM
//   MEM_MisalignErr        - word access with addr[1:0] != 0 this cycle
//   Out_*                  - MEM/WB payload (controls, load data, ALU result, dest reg)
module mem_access_stage #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        MEM_MemtoReg,
  input  logic        MEM_RegWrite,
  input  logic        MEM_ByteOp,
  input  logic        MEM_Unsigned,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_WriteData,
  input  logic [4:0]  MEM_WriteReg,
  output logic        MEM_Stall,
  output logic        MEM_MisalignErr,
  output logic        Out_MemtoReg,
  output logic        Out_RegWrite,
  output logic        Out_MemRead,
  output logic [31:0] Out_ReadData,
  output logic [31:0] Out_ALUResult,
  output logic [4:0]  Out_WriteReg
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mem [DEPTH];

  logic          access, misalign, go;
  logic          stall, complete, we, rd_en;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   rword, load_val, wword;
  logic [7:0]    rbyte;
  logic          unused_addr_bits;

  // Address decode; upper address bits wrap.
  assign widx             = MEM_ALUResult[AW+1:2];
  assign lane             = MEM_ALUResult[1:0];
  assign unused_addr_bits = ^MEM_ALUResult[31:AW+2];

  assign access   = MEM_MemRead | MEM_MemWrite;
  assign misalign = access & ~MEM_ByteOp & (lane != 2'b00);
  assign go       = access & ~misalign;

  // Access sequencing: stall for LAT cycles, complete in the following cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    if (LAT == 0) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      complete = go;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            stall   = 1'b1;
            state_d = (LAT == 1) ? S_DONE : S_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        S_WAIT: begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          // Last wait cycle is the one whose incremented count reaches LAT.
          if ((32'(cnt_q) + 32'd1) == LAT) state_d = S_DONE;
        end
        S_DONE: begin
          // Inputs are held during the stall, so go is normally set here.
          complete = go;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    if (reset) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      stall    = 1'b0;
      complete = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read path: combinational word read, lane select and extension.
  always_comb begin
    rword = mem[widx];
    rbyte = rword[{lane, 3'b000} +: 8];
    if (!MEM_ByteOp)       load_val = rword;
    else if (MEM_Unsigned) load_val = {24'h000000, rbyte};
    else                   load_val = {{24{rbyte[7]}}, rbyte};
  end

  // Write data: sb merges one lane into the current word.
  always_comb begin
    wword = rword;
    if (MEM_ByteOp) wword[{lane, 3'b000} +: 8] = MEM_WriteData[7:0];
    else            wword = MEM_WriteData;
  end

  // A simultaneous read+write is a store; no load data is returned.
  assign we    = complete & MEM_MemWrite;
  assign rd_en = complete & MEM_MemRead & ~MEM_MemWrite;

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wword;
  end

  assign MEM_Stall       = stall;
  assign MEM_MisalignErr = misalign & ~reset;
  assign Out_RegWrite    = ~reset & ~stall & ~misalign & MEM_RegWrite;
  assign Out_MemtoReg    = ~reset & ~stall & MEM_MemtoReg;
  assign Out_MemRead     = ~reset & ~stall & MEM_MemRead;
  assign Out_ReadData    = rd_en ? load_val : 32'h0;
  assign Out_ALUResult   = MEM_ALUResult;
  assign Out_WriteReg    = MEM_WriteReg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: four instances with LAT = 0..3 (instance index
// equals LAT), a byte-array reference memory per instance, table vectors,
// hand sequences for the corner cases and randomized operations.
module tb_mem_access_stage;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned NB    = DEPTH * 4;
  localparam int          NI    = 4;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        mtr;
    logic        rw;
    logic        bop;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  wreg;
  } in_t;

  typedef struct {
    in_t         in;
    logic [31:0] rdata;
    logic        rw;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [NI];
  in_t         din     [NI];
  logic        stall_o [NI];
  logic        err_o   [NI];
  logic        mtr_o   [NI];
  logic        rw_o    [NI];
  logic        mr_o    [NI];
  logic [31:0] rdata_o [NI];
  logic [31:0] alu_o   [NI];
  logic [4:0]  wreg_o  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_access_stage #(.DEPTH(DEPTH), .LAT(g)) u_dut (
      .clk            (clk),
      .reset          (rst[g]),
      .MEM_MemRead    (din[g].rd),
      .MEM_MemWrite   (din[g].wr),
      .MEM_MemtoReg   (din[g].mtr),
      .MEM_RegWrite   (din[g].rw),
      .MEM_ByteOp     (din[g].bop),
      .MEM_Unsigned   (din[g].uns),
      .MEM_ALUResult  (din[g].addr),
      .MEM_WriteData  (din[g].wdata),
      .MEM_WriteReg   (din[g].wreg),
      .MEM_Stall      (stall_o[g]),
      .MEM_MisalignErr(err_o[g]),
      .Out_MemtoReg   (mtr_o[g]),
      .Out_RegWrite   (rw_o[g]),
      .Out_MemRead    (mr_o[g]),
      .Out_ReadData   (rdata_o[g]),
      .Out_ALUResult  (alu_o[g]),
      .Out_WriteReg   (wreg_o[g])
    );
  end

  // Reference memory, one byte array per instance, zero at start.
  logic [7:0] mdl [NI][NB];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  function automatic in_t mk(input logic rd, input logic wr, input logic rw, input logic mtr,
                             input logic bop, input logic uns, input logic [31:0] addr,
                             input logic [31:0] wdata);
    in_t x;
    x.rd = rd; x.wr = wr; x.rw = rw; x.mtr = mtr; x.bop = bop; x.uns = uns;
    x.addr = addr; x.wdata = wdata;
    x.wreg = addr[6:2] ^ 5'h0A;
    return x;
  endfunction

  function automatic logic is_misaligned(input in_t x);
    return (x.rd || x.wr) && !x.bop && ((x.addr % 4) != 0);
  endfunction

  function automatic logic [31:0] mdl_load(input int i, input in_t x);
    int unsigned ba, wb;
    logic [7:0]  b;
    ba = x.addr % NB;
    wb = ba - (ba % 4);
    b  = mdl[i][ba];
    if (!x.bop) return {mdl[i][wb+3], mdl[i][wb+2], mdl[i][wb+1], mdl[i][wb]};
    if (x.uns)  return {24'h000000, b};
    return {{24{b[7]}}, b};
  endfunction

  function automatic void mdl_store(input int i, input in_t x);
    int unsigned ba;
    ba = x.addr % NB;
    if (x.bop) mdl[i][ba] = x.wdata[7:0];
    else for (int k = 0; k < 4; k++) mdl[i][ba+k] = x.wdata[8*k +: 8];
  endfunction

  // Present one instruction to instance i, hold it through the stall, and
  // check every cycle against the model. Returns load data of the last cycle.
  task automatic run_op(input int i, input in_t x, output logic [31:0] rd_last);
    logic  acc, mis;
    int    ncyc;
    string t;
    acc  = x.rd | x.wr;
    mis  = is_misaligned(x);
    ncyc = (acc && !mis) ? i + 1 : 1;
    din[i]  = x;
    rd_last = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      t = $sformatf("L%0d c%0d a=%h", i, c, x.addr);
      chk({t, " alu"}, alu_o[i], x.addr);
      chk({t, " wreg"}, 32'(wreg_o[i]), 32'(x.wreg));
      if (c < ncyc - 1) begin
        chk1({t, " stall"}, stall_o[i], 1'b1);
        chk1({t, " rw_bubble"}, rw_o[i], 1'b0);
        chk1({t, " mtr_bubble"}, mtr_o[i], 1'b0);
        chk1({t, " mr_bubble"}, mr_o[i], 1'b0);
        chk1({t, " err"}, err_o[i], 1'b0);
        chk({t, " rdata_bubble"}, rdata_o[i], 32'h0);
      end else begin
        chk1({t, " stall"}, stall_o[i], 1'b0);
        chk1({t, " err"}, err_o[i], mis);
        chk1({t, " rw"}, rw_o[i], x.rw && !mis);
        chk1({t, " mtr"}, mtr_o[i], x.mtr);
        chk1({t, " mr"}, mr_o[i], x.rd);
        chk({t, " rdata"}, rdata_o[i], (x.rd && !x.wr && !mis) ? mdl_load(i, x) : 32'h0);
        rd_last = rdata_o[i];
      end
      @(posedge clk); #1;
    end
    if (x.wr && !mis) mdl_store(i, x);
    din[i] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl [6];
    in_t         x;
    logic [31:0] r;
    int          op;

    for (int i = 0; i < NI; i++) begin
      din[i] = '0;
      rst[i] = 1'b1;
      for (int b = 0; b < int'(NB); b++) mdl[i][b] = 8'h00;
    end

    // Reset: outputs forced quiet, no write on the reset edge.
    @(posedge clk); #1;
    din[0] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'hCAFEF00D);
    din[1] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    din[2] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h06, 32'h0);
    din[3] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk1($sformatf("rst L%0d stall", i), stall_o[i], 1'b0);
        chk1($sformatf("rst L%0d err", i), err_o[i], 1'b0);
        chk1($sformatf("rst L%0d rw", i), rw_o[i], 1'b0);
        chk1($sformatf("rst L%0d mtr", i), mtr_o[i], 1'b0);
        chk1($sformatf("rst L%0d mr", i), mr_o[i], 1'b0);
        chk($sformatf("rst L%0d rdata", i), rdata_o[i], 32'h0);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b0;
      din[i] = '0;
    end
    run_op(0, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0), r);
    chk("rst_no_write", r, 32'h0);

    // LAT=0 table: single-cycle accesses, byte lanes and extension.
    tbl[0] = '{mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h11223344), 32'h0, 1'b0, 1'b0};
    tbl[1] = '{mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h13, 32'h000000A5), 32'h0, 1'b0, 1'b0};
    tbl[2] = '{mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0), 32'hA5223344, 1'b1, 1'b0};
    tbl[3] = '{mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h13, 32'h0), 32'hFFFFFFA5, 1'b1, 1'b0};
    tbl[4] = '{mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h13, 32'h0), 32'h000000A5, 1'b1, 1'b0};
    tbl[5] = '{mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h12, 32'h0), 32'h0, 1'b0, 1'b1};
    for (int k = 0; k < 6; k++) begin
      din[0] = tbl[k].in;
      @(negedge clk);
      chk1($sformatf("tbl%0d stall", k), stall_o[0], 1'b0);
      chk($sformatf("tbl%0d rdata", k), rdata_o[0], tbl[k].rdata);
      chk1($sformatf("tbl%0d rw", k), rw_o[0], tbl[k].rw);
      chk1($sformatf("tbl%0d err", k), err_o[0], tbl[k].err);
      @(posedge clk); #1;
      if (tbl[k].in.wr && !is_misaligned(tbl[k].in)) mdl_store(0, tbl[k].in);
    end
    din[0] = '0;

    // LAT=2: store then load, two stall cycles each.
    run_op(2, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF), r);
    run_op(2, mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0), r);
    chk("lat2_lw", r, 32'hDEADBEEF);

    // LAT=2: misaligned store suppressed, misaligned load flagged.
    run_op(2, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h06, 32'hFFFFFFFF), r);
    run_op(2, mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h04, 32'h0), r);
    chk("misalign_sw_dropped", r, 32'h0);
    run_op(2, mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h06, 32'h0), r);

    // Address wrap modulo DEPTH*4.
    run_op(2, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h400, 32'h12345678), r);
    run_op(2, mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h000, 32'h0), r);
    chk("wrap_lw", r, 32'h12345678);

    // LAT=1: read+write together is a store.
    run_op(1, mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h7), r);
    chk("rdwr_rdata", r, 32'h0);
    run_op(1, mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0), r);
    chk("rdwr_then_lw", r, 32'h7);

    // LAT=3: reset in the second wait cycle aborts the store.
    din[3] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h55);
    @(negedge clk);
    chk1("abort idle stall", stall_o[3], 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("abort wait1 stall", stall_o[3], 1'b1);
    @(posedge clk); #1;
    rst[3] = 1'b1;
    @(negedge clk);
    chk1("abort rst stall", stall_o[3], 1'b0);
    chk1("abort rst rw", rw_o[3], 1'b0);
    @(posedge clk); #1;
    rst[3] = 1'b0;
    din[3] = '0;
    @(negedge clk);
    chk1("abort after stall", stall_o[3], 1'b0);
    @(posedge clk); #1;
    run_op(3, mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0), r);
    chk("abort_lw_old", r, 32'h0);

    // Randomized operations on every latency against the reference memory.
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 60; n++) begin
        x       = '0;
        op      = int'($urandom_range(0, 5));
        x.rd    = (op == 1) || (op == 2) || (op == 4);
        x.wr    = (op == 3) || (op == 4) || (op == 5);
        x.bop   = 1'($urandom_range(0, 1));
        x.uns   = 1'($urandom_range(0, 1));
        x.rw    = 1'($urandom_range(0, 1));
        x.mtr   = 1'($urandom_range(0, 1));
        x.addr  = 32'($urandom_range(0, 127));
        if ($urandom_range(0, 3) == 0) x.addr = x.addr | ($urandom() & 32'hFFFFFC00);
        if (!x.bop && $urandom_range(0, 3) != 0) x.addr[1:0] = 2'b00;
        x.wdata = $urandom();
        x.wreg  = 5'($urandom_range(0, 31));
        run_op(i, x, r);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
